// File: rtl/abs_diff_line_feeder.sv
// abs_diff_line_feeder
//   Producer side of the sub-pel line difference stage. Streams BLK_ROWS+2
//   reference rows and BLK_ROWS original rows, keeps a sliding 3-row window
//   and presents registered upper/middle/lower reference rows plus the
//   matching original row, one line per line_valid/line_ready handshake.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   start                       one-cycle pulse, begins a block when idle
//   ref_valid/ref_ready/ref_pix reference row stream (pixel 0 in [7:0])
//   org_valid/org_ready/org_in  original row stream
//   line_valid/line_ready       output line handshake
//   cur_upper/middle/lower_pix  reference rows k-1, k, k+1
//   org_pix                     original row aligned with cur_middle_pix
//   line_idx, line_last         index of the presented line, last-line flag
//   busy, done                  block in progress, end-of-block pulse

// One 8-bit pixel column of the window and the output line registers.
module abs_diff_lane #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_w0,
  input  logic             load_w1,
  input  logic             adv,
  input  logic [PIX_W-1:0] ref_px,
  input  logic [PIX_W-1:0] org_px,
  output logic [PIX_W-1:0] upper,
  output logic [PIX_W-1:0] middle,
  output logic [PIX_W-1:0] lower,
  output logic [PIX_W-1:0] org
);
  logic [PIX_W-1:0] w0, w1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0     <= '0;
      w1     <= '0;
      upper  <= '0;
      middle <= '0;
      lower  <= '0;
      org    <= '0;
    end else if (adv) begin
      // present the window and slide it by one row in the same edge
      upper  <= w0;
      middle <= w1;
      lower  <= ref_px;
      org    <= org_px;
      w0     <= w1;
      w1     <= ref_px;
    end else begin
      if (load_w0) w0 <= ref_px;
      if (load_w1) w1 <= ref_px;
    end
  end
endmodule

module abs_diff_line_feeder #(
  parameter int BLK_ROWS = 8,
  parameter int CNT_W    = $clog2(BLK_ROWS+2)+1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [63:0] ref_pix,
  input  logic        org_valid,
  output logic        org_ready,
  input  logic [63:0] org_in,
  output logic        line_valid,
  input  logic        line_ready,
  output logic [63:0] cur_upper_pix,
  output logic [63:0] cur_middle_pix,
  output logic [63:0] cur_lower_pix,
  output logic [63:0] org_pix,
  output logic [5:0]  line_idx,
  output logic        line_last,
  output logic        busy,
  output logic        done
);
  localparam int NUM_LANES = 8;
  localparam int PIX_W     = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME0 = 3'd1;
  localparam logic [2:0] S_PRIME1 = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_ROWS-1);

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic             slot_free, accept, ref_hs, line_hs, load_w0, load_w1;

  logic [NUM_LANES-1:0][PIX_W-1:0] ref_lanes, org_lanes;
  logic [NUM_LANES-1:0][PIX_W-1:0] upper_lanes, middle_lanes, lower_lanes, orgo_lanes;

  // Output register slot can take a new line if empty or being drained now.
  always_comb begin
    slot_free = !line_valid || line_ready;
    ref_ready = 1'b0;
    org_ready = 1'b0;
    case (state)
      S_PRIME0, S_PRIME1: ref_ready = 1'b1;
      S_RUN: begin
        // each ready waits on the partner valid so the streams move jointly
        ref_ready = slot_free && org_valid;
        org_ready = slot_free && ref_valid;
      end
      default: ;
    endcase
  end

  assign ref_hs  = ref_valid && ref_ready;
  assign accept  = (state == S_RUN) && slot_free && ref_valid && org_valid;
  assign line_hs = line_valid && line_ready;
  assign load_w0 = (state == S_PRIME0) && ref_hs;
  assign load_w1 = (state == S_PRIME1) && ref_hs;

  assign ref_lanes = ref_pix;
  assign org_lanes = org_in;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    abs_diff_lane #(.PIX_W(PIX_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_w0(load_w0),
      .load_w1(load_w1),
      .adv    (accept),
      .ref_px (ref_lanes[i]),
      .org_px (org_lanes[i]),
      .upper  (upper_lanes[i]),
      .middle (middle_lanes[i]),
      .lower  (lower_lanes[i]),
      .org    (orgo_lanes[i])
    );
  end

  assign cur_upper_pix  = upper_lanes;
  assign cur_middle_pix = middle_lanes;
  assign cur_lower_pix  = lower_lanes;
  assign org_pix        = orgo_lanes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      line_valid <= 1'b0;
      line_idx   <= '0;
      line_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PRIME0;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        S_PRIME0: if (ref_hs) state <= S_PRIME1;
        S_PRIME1: if (ref_hs) state <= S_RUN;
        S_RUN: begin
          if (accept) begin
            line_valid <= 1'b1;
            line_idx   <= 6'(count);
            line_last  <= (count == LAST_CNT);
            count      <= count + CNT_W'(1);
            // the final accept ends intake; count never passes BLK_ROWS
            if (count == LAST_CNT) state <= S_DRAIN;
          end else if (line_hs) begin
            line_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (line_hs && line_last) begin
            line_valid <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_abs_diff_line_feeder.sv
module tb_abs_diff_line_feeder;
  localparam int NLINE = 8;
  localparam int NREF  = NLINE + 2;

  logic        clk, rst, start;
  logic        ref_valid, ref_ready, org_valid, org_ready;
  logic [63:0] ref_pix, org_in;
  logic        line_valid, line_ready;
  logic [63:0] cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix;
  logic [5:0]  line_idx;
  logic        line_last, busy, done;

  abs_diff_line_feeder #(.BLK_ROWS(NLINE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pix(ref_pix),
    .org_valid(org_valid), .org_ready(org_ready), .org_in(org_in),
    .line_valid(line_valid), .line_ready(line_ready),
    .cur_upper_pix(cur_upper_pix), .cur_middle_pix(cur_middle_pix),
    .cur_lower_pix(cur_lower_pix), .org_pix(org_pix),
    .line_idx(line_idx), .line_last(line_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: the rows of the current block and stream positions
  logic [63:0] ref_rows [NREF];
  logic [63:0] org_rows [NLINE];
  int ref_i, org_i, line_n, done_n, cyc_n, done_cyc;
  int line_cyc [NLINE];
  int p_ref, p_org, p_rdy;
  int stall_idx, stall_left, orglow_at, orglow_left;
  bit start_pulse, start_at_done;
  bit rh_p, oh_p, lh_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Line k of a block is reference rows k..k+2 with original row k.
  task automatic check_line();
    int k;
    k = line_n;
    if (k >= NLINE) begin
      check("extra_line", 64'(k), 64'(NLINE-1));
    end else begin
      check("upper",  cur_upper_pix,  ref_rows[k]);
      check("middle", cur_middle_pix, ref_rows[k+1]);
      check("lower",  cur_lower_pix,  ref_rows[k+2]);
      check("org",    org_pix,        org_rows[k]);
      check("line_idx",  64'(line_idx),  64'(k));
      check("line_last", 64'(line_last), 64'(k == NLINE-1));
    end
  endtask

  task automatic cyc();
    bit stalled, olow;
    @(negedge clk);
    if (rh_p) begin ref_i++; ref_valid = 1'b0; end
    if (oh_p) begin org_i++; org_valid = 1'b0; end
    if (lh_p) line_n++;
    rh_p = 0; oh_p = 0; lh_p = 0;
    cyc_n++;
    // valids are held until accepted, then re-rolled
    if (!ref_valid) ref_valid = (ref_i < NREF)  && ($urandom_range(99) < p_ref);
    if (!org_valid) org_valid = (org_i < NLINE) && ($urandom_range(99) < p_org);
    olow = (orglow_left > 0) && (org_i == orglow_at);
    if (olow) begin
      org_valid = 1'b0;
      ref_valid = (ref_i < NREF);
      orglow_left--;
    end
    ref_pix = ref_valid ? ref_rows[ref_i] : {$urandom, $urandom};
    org_in  = org_valid ? org_rows[org_i] : {$urandom, $urandom};
    stalled = line_valid && (line_n == stall_idx) && (stall_left > 0);
    if (stalled) begin
      line_ready = 1'b0;
      stall_left--;
    end else begin
      line_ready = ($urandom_range(99) < p_rdy);
    end
    start = start_pulse;
    start_pulse = 0;
    #1;
    if (line_valid) check_line();
    if (stalled) begin
      check("stall_ref_ready", 64'(ref_ready), 64'(0));
      check("stall_org_ready", 64'(org_ready), 64'(0));
    end
    if (olow) check("orglow_ref_ready", 64'(ref_ready), 64'(0));
    rh_p = ref_valid && ref_ready;
    oh_p = org_valid && org_ready;
    lh_p = line_valid && line_ready;
    if (oh_p) check("joint_accept", 64'(rh_p), 64'(1));
    if (lh_p && line_n < NLINE) line_cyc[line_n] = cyc_n;
    if (lh_p && line_last && start_at_done) start = 1'b1;
    if (done) begin done_n++; done_cyc = cyc_n; end
  endtask

  task automatic init_block(input bit directed);
    logic [7:0] b;
    for (int i = 0; i < NREF; i++) begin
      b = 8'h10 + 8'(i);
      ref_rows[i] = directed ? {8{b}} : {$urandom, $urandom};
    end
    for (int i = 0; i < NLINE; i++) begin
      b = 8'hA0 + 8'(i);
      org_rows[i] = directed ? {8{b}} : {$urandom, $urandom};
    end
    ref_i = 0; org_i = 0; line_n = 0; done_n = 0; done_cyc = -1;
    for (int i = 0; i < NLINE; i++) line_cyc[i] = -100;
    ref_valid = 1'b0; org_valid = 1'b0;
  endtask

  task automatic run_block(input bit directed, input int pr, input int po, input int pl,
                           input bit mid_start, input bit at_done);
    bit mid_used;
    init_block(directed);
    p_ref = pr; p_org = po; p_rdy = pl;
    start_at_done = at_done;
    mid_used = 0;
    start_pulse = 1;
    for (int c = 0; c < 600 && done_n == 0; c++) begin
      if (mid_start && !mid_used && line_n == 2) begin
        start_pulse = 1;
        mid_used = 1;
      end
      cyc();
    end
    check("done_seen", 64'(done_n), 64'(1));
    start_at_done = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("idle_after_done", 64'(busy), 64'(0));
    end
    check("ref_count",  64'(ref_i),  64'(NREF));
    check("org_count",  64'(org_i),  64'(NLINE));
    check("line_count", 64'(line_n), 64'(NLINE));
    check("done_pulses", 64'(done_n), 64'(1));
    check("done_timing", 64'(done_cyc), 64'(line_cyc[NLINE-1] + 1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ref_valid = 1'b0; org_valid = 1'b0; line_ready = 1'b0;
    ref_pix = '0; org_in = '0;
    cyc_n = 0; stall_idx = -1; stall_left = 0; orglow_at = -1; orglow_left = 0;
    start_pulse = 0; start_at_done = 0; rh_p = 0; oh_p = 0; lh_p = 0;
    p_ref = 0; p_org = 0; p_rdy = 0;
    init_block(1'b1);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_line_valid", 64'(line_valid), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_ref_ready", 64'(ref_ready), 64'(0));
    check("rst_org_ready", 64'(org_ready), 64'(0));
    check("rst_upper", cur_upper_pix, 64'(0));
    check("rst_line_idx", 64'(line_idx), 64'(0));
    rst = 1'b0;
    // idle ignores valid inputs
    p_ref = 100; p_org = 100; p_rdy = 100;
    cyc();
    check("idle_ref_ready", 64'(ref_ready), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    p_ref = 0; p_org = 0;
    ref_valid = 1'b0; org_valid = 1'b0; rh_p = 0; oh_p = 0;

    // directed full-rate block, start repeated on the done handshake
    run_block(1'b1, 100, 100, 100, 1'b0, 1'b1);
    check("back_to_back", 64'(line_cyc[NLINE-1] - line_cyc[0]), 64'(NLINE-1));

    // output stall on line 3, then org stream gap in RUN
    stall_idx = 3; stall_left = 5; orglow_at = 5; orglow_left = 3;
    run_block(1'b0, 100, 100, 100, 1'b0, 1'b0);
    check("stall_done", 64'(stall_left), 64'(0));
    check("orglow_done", 64'(orglow_left), 64'(0));
    check("line4_after_stall", 64'(line_cyc[4] - line_cyc[3]), 64'(1));
    stall_idx = -1; orglow_at = -1;

    // random gaps on all streams, stray starts mid-block and at done
    for (int b = 0; b < 3; b++) run_block(1'b0, 50, 50, 50, 1'b1, 1'b1);

    // reset in the middle of RUN with a line presented
    init_block(1'b0);
    p_ref = 100; p_org = 100; p_rdy = 100;
    start_pulse = 1;
    for (int c = 0; c < 100 && !(line_n >= 3 && line_valid); c++) cyc();
    check("reached_line3", 64'(line_n >= 3 && line_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_line_valid", 64'(line_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ref_ready", 64'(ref_ready), 64'(0));
    check("mid_rst_org_ready", 64'(org_ready), 64'(0));
    check("mid_rst_upper", cur_upper_pix, 64'(0));
    check("mid_rst_middle", cur_middle_pix, 64'(0));
    check("mid_rst_lower", cur_lower_pix, 64'(0));
    check("mid_rst_org", org_pix, 64'(0));
    check("mid_rst_idx", 64'(line_idx), 64'(0));
    check("mid_rst_last", 64'(line_last), 64'(0));
    rh_p = 0; oh_p = 0; lh_p = 0;
    ref_valid = 1'b0; org_valid = 1'b0;
    p_ref = 0; p_org = 0;
    done_n = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("post_rst_idle", 64'(busy), 64'(0));
    end
    check("no_done_on_rst", 64'(done_n), 64'(0));
    run_block(1'b1, 100, 100, 100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/abs_diff_line_feeder.md
Name: abs_diff_line_feeder

Overview:
- Producer side of the sub-pel line difference stage.
- Accepts a stream of 64-bit reference rows (8 pixels x 8 bit) and a stream of 64-bit original-block rows.
- Maintains a sliding 3-row window and presents registered upper/middle/lower reference rows plus the matching original row, one line per handshake, for a block of BLK_ROWS lines.
- Sits between the reference/original row fetch and the line-difference datapath.

Parameters:
- BLK_ROWS, 8, output lines per block. Legal range 1..64. Reference rows consumed per block = BLK_ROWS+2; original rows consumed = BLK_ROWS.
- CNT_W, $clog2(BLK_ROWS+2)+1, width of the internal row counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a block when idle.
- ref_valid  in  1  ref_pix is valid.
- ref_ready  out  1  feeder accepts ref_pix this cycle.
- ref_pix  in  64  reference row, pixel 0 in bits [7:0].
- org_valid  in  1  org_in is valid.
- org_ready  out  1  feeder accepts org_in this cycle.
- org_in  in  64  original row.
- line_valid  out  1  output line registers hold a valid line.
- line_ready  in  1  downstream accepts the line.
- cur_upper_pix  out  64  reference row k-1.
- cur_middle_pix  out  64  reference row k.
- cur_lower_pix  out  64  reference row k+1.
- org_pix  out  64  original row aligned with cur_middle_pix.
- line_idx  out  6  index 0..BLK_ROWS-1 of the presented line.
- line_last  out  1  presented line is BLK_ROWS-1.
- busy  out  1  high from the accepted start through the cycle before done.
- done  out  1  one-cycle pulse when the last line handshakes.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: line_valid, busy, done, ref_ready, org_ready, all pixel buses, line_idx, line_last. Window registers w0/w1 and counters are cleared.
- Reset asserted mid-block abandons the block; no done pulse is issued. After release the feeder sits in IDLE until the next start.
- States: IDLE, PRIME0, PRIME1, RUN, DRAIN.
- IDLE
  - start=1: go to PRIME0, busy<=1, line counter<=0.
  - start in any other state is ignored.
  - ref_ready=org_ready=0.
- PRIME0
  - ref_ready=1, org_ready=0.
  - On ref handshake: w0<=ref_pix, go to PRIME1.
- PRIME1
  - ref_ready=1, org_ready=0.
  - On ref handshake: w1<=ref_pix, go to RUN.
- RUN
  - Output slot free: slot_free = !line_valid || line_ready.
  - ref_ready = slot_free && org_valid; org_ready = slot_free && ref_valid.
  - Ready may depend on the partner valid; valid never depends on ready.
  - Both streams are accepted jointly in the same cycle, never one alone.
  - On joint accept, next edge:
    - cur_upper_pix<=w0, cur_middle_pix<=w1, cur_lower_pix<=ref_pix, org_pix<=org_in.
    - line_idx<=count, line_last<=(count==BLK_ROWS-1), line_valid<=1.
    - w0<=w1, w1<=ref_pix, count<=count+1.
  - On the accept with count==BLK_ROWS-1: go to DRAIN.
  - Handshake without a new accept: line_valid<=0.
- Output hold: while line_valid && !line_ready, all output buses, line_idx and line_last are stable.
- Throughput: one line per cycle in RUN when all valids and line_ready stay high.
- Latency: 1 cycle from joint accept to line_valid.
- DRAIN
  - ref_ready=org_ready=0.
  - On line handshake with line_last=1: line_valid<=0, done<=1 for one cycle, busy<=0, go to IDLE.
  - Pixel buses keep their last values after done.
- start in the same cycle as the done handshake is ignored; a new block needs start in IDLE.
- BLK_ROWS=1: PRIME0, PRIME1, one RUN accept, DRAIN.
- Counters saturate only through the state transitions. No wrap beyond BLK_ROWS.
- Pure data movement; no arithmetic on pixels.

Test Plan:
- Reset mid-RUN with line_valid=1 -> next cycle all outputs 0, state IDLE; no done; a later start restarts cleanly from PRIME0.
- BLK_ROWS=8, ref rows R0..R9 = {8{8'h10+i}}, org rows O0..O7 = {8{8'hA0+i}}, all valids/ready high, start at t0:
  - Line k shows upper=R(k), middle=R(k+1), lower=R(k+2), org=Ok, line_idx=k.
  - Lines appear on 8 consecutive cycles; line_last only on k=7; done 1 cycle after the k=7 handshake; exactly 10 ref and 8 org handshakes.
- line_ready held low for 5 cycles while line 3 is presented -> buses and line_idx=3 stable; ref_ready=org_ready=0 during the stall; line 4 follows the cycle after line_ready rises.
- org_valid low while ref_valid high in RUN -> ref_ready=0; neither stream advances; no line emitted.
- Random valid/ready gaps (50% duty), BLK_ROWS=3 -> scoreboard matches window sequence R0/R1/R2, R1/R2/R3, R2/R3/R4; single done pulse.
- start pulsed during RUN, and again at the done cycle -> ignored; the block completes with exactly BLK_ROWS lines.
